// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32-bit multiply/divide unit with architectural HI/LO.
//
// Takes one operand bit per cycle. A shift-add multiply or a restoring divide
// runs for 32 cycles in CALC. One FIX cycle follows, which applies signs and
// writes HI/LO. MTHI/MTLO load HI/LO directly while the unit is idle.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     begin operation `op` on src_a/src_b (accepted only when idle)
//   op        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src_a     multiplicand / dividend, or MTHI/MTLO data
//   src_b     multiplier / divisor
//   wr_hi     MTHI: load src_a into HI (idle, no start)
//   wr_lo     MTLO: load src_a into LO (idle, no start)
//   busy      operation in progress
//   done      one-cycle pulse, HI/LO hold the new result
//   div_zero  with done: divide by zero was attempted, HI/LO unchanged
//   hi, lo    architectural HI/LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t                    state;
  logic [4:0]                count;
  logic                      dz;

  // Datapath registers carry no reset; the FSM decides when they are valid.
  logic [2*DATA_W-1:0]       acc;
  logic [DATA_W-1:0]         mag_a;
  logic [DATA_W-1:0]         mag_b;
  logic                      is_div;
  logic                      neg_q;
  logic                      neg_r;

  logic signed [DATA_W-1:0]  a_s;
  logic signed [DATA_W-1:0]  b_s;
  logic                      a_neg;
  logic                      b_neg;
  logic                      b_zero;

  logic [DATA_W:0]           mul_sum;
  logic [2*DATA_W-1:0]       mul_next;
  logic [DATA_W:0]           div_shift;
  logic [DATA_W:0]           div_diff;
  logic [2*DATA_W-1:0]       div_next;
  logic [2*DATA_W-1:0]       prod;
  logic [DATA_W-1:0]         res_hi;
  logic [DATA_W-1:0]         res_lo;

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v);
    return ~v + {{(2*DATA_W-1){1'b0}}, 1'b1};
  endfunction

  assign a_s    = src_a;
  assign b_s    = src_b;
  assign a_neg  = op[0] && (a_s < 0);
  assign b_neg  = op[0] && (b_s < 0);
  assign b_zero = (src_b == '0);
  assign busy   = (state != S_IDLE);

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  // Add the multiplicand into the upper half when the current multiplier
  // bit is set, then shift the 65-bit {carry, acc} right by one.
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} +
                    {1'b0, (acc[0] ? mag_a : {DATA_W{1'b0}})};
  assign mul_next = {mul_sum, acc[DATA_W-1:1]};

  // Divide step: acc = {remainder, dividend bits / quotient bits}.
  // A 33-bit trial subtract is enough: its top bit is a correct borrow
  // because the shifted remainder is always below 2*divisor.
  assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};
  assign div_next  = div_diff[DATA_W] ?
                     {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0} :
                     {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};

  always_comb begin
    prod   = neg_q ? neg64(acc) : acc;
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (is_div) begin
      res_lo = neg_q ? neg32(acc[DATA_W-1:0]) : acc[DATA_W-1:0];
      res_hi = neg_r ? neg32(acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];
    end
  end

  // Operand capture at start, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      is_div <= op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      mag_a  <= a_neg ? neg32(src_a) : src_a;
      mag_b  <= b_neg ? neg32(src_b) : src_b;
      acc    <= {{DATA_W{1'b0}},
                 (op[1] ? (a_neg ? neg32(src_a) : src_a)
                        : (b_neg ? neg32(src_b) : src_b))};
    end else if (state == S_CALC) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

  // Control FSM and the architectural HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      dz       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count <= 5'd31;
            dz    <= op[1] && b_zero;
            state <= (op[1] && b_zero) ? S_FIX : S_CALC;
          end else begin
            if (wr_hi) hi <= src_a;
            if (wr_lo) lo <= src_a;
          end
        end
        S_CALC: begin
          count <= count - 5'd1;
          if (count == 5'd0) state <= S_FIX;
        end
        S_FIX: begin
          done     <= 1'b1;
          div_zero <= dz;
          if (!dz) begin
            hi <= res_hi;
            lo <= res_lo;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS-style core. Sits directly downstream of the register file read ports and consumes the two source operands for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Its `hi`/`lo` outputs feed the writeback mux, so MFHI/MFLO results return to the register file write-data port. Decode/stall logic upstream holds the pipeline while `busy` is high.

## Interface
- Parameters: none; datapath fixed at 32 bits (64-bit product).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin operation `op` on `src_a`/`src_b`; accepted only in IDLE.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `src_a`  in  32  operand A: multiplicand/dividend, or MTHI/MTLO data (register file data1).
- `src_b`  in  32  operand B: multiplier/divisor (register file data2).
- `wr_hi`  in  1  MTHI: load `src_a` into HI.
- `wr_lo`  in  1  MTLO: load `src_a` into LO.
- `busy`  out  1  operation in progress; decoded from state.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_zero`  out  1  valid with `done`; divide attempted with `src_b` == 0.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start`=1: latch |A|, |B| (for signed ops; raw values for unsigned), `op`, and the result sign; clear accumulator; count = 31; go to CALC.
- IDLE, `start`=1, op DIVU/DIV, `src_b`==0: go straight to FIX with the zero flag set; no iterations.
- CALC multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- CALC divide: restoring division, one quotient bit per cycle; 32-bit remainder, 33-bit trial subtract.
- CALC: count decrements each cycle; at count 0 go to FIX.
- FIX multiply: negate the 64-bit product if the operand signs differ (MULT only); HI = [63:32], LO = [31:0].
- FIX divide: LO = quotient, negated if the operand signs differ (DIV only); HI = remainder, taking the dividend's sign (DIV only).
- FIX with divide-by-zero: HI/LO unchanged, `div_zero`=1.
- FIX always pulses `done` and returns to IDLE.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: magnitude path gives LO=0x80000000, HI=0; no trap.
- MTHI/MTLO: in IDLE with `start`=0, `wr_hi`/`wr_lo` load `src_a` at the clock edge. Both high loads both registers.
- Ignored inputs:
  - `start`, `wr_hi`, `wr_lo` while `busy`=1.
  - `wr_hi`/`wr_lo` in the same cycle as an accepted `start` (start wins).
- Reset, asynchronous, any state including mid-CALC:
  - state → IDLE.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, counter=0.
  - Any operation in progress is discarded.

## Timing
- `start` sampled at edge k.
- `busy`=1 from after edge k through edge k+33 (33 cycles: 32 CALC + 1 FIX).
- `hi`/`lo` update at edge k+33.
- `done` (registered) is high for the cycle after edge k+33, when `busy` is already 0.
- Back-to-back `start` is allowed in the cycle `done` is high.
- Divide-by-zero: FIX at edge k+1; `done`/`div_zero` are high the cycle after edge k+1; `busy` is high for 1 cycle.
- MTHI/MTLO: the written value is visible on `hi`/`lo` the cycle after the edge; no bypass.
- `div_zero` is low whenever `done` is low.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 33 cycles after the start edge; `busy` high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIVU 100 / 7 → LO=14, HI=2.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI=0x1234, LO=0x5678 via MTHI/MTLO, then DIVU 5 / 0 → `done` and `div_zero` high the cycle after edge k+1; HI=0x1234, LO=0x5678.
- Start MULT 6 × 7.
  - Pulse `start` with MULTU 1×1 and `wr_hi` at cycle 5 → ignored.
  - Assert `rst` asynchronously at cycle 10 → `busy`, `hi`, `lo` = 0 immediately; no `done`.
  - After release, MULTU 6 × 7 → LO=42, HI=0.
